// File: rtl/bcd_mmss_timer.sv
// bcd_mmss_timer: MM:SS BCD timer (run/pause, clear, up/down, rollover pulse) driving a 4-digit muxed 7-seg display.
// Latency: q and wrap change on the tick edge; an/a_to_g/dp are registered one cycle behind the digit index.
// Backpressure: none; free-running. Optional LEAD_ZERO_BLANK_EN blanks a leading minutes-tens zero.

module bcd_mmss_timer #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned SCAN_HZ = 1000,
  parameter int unsigned SEC_MOD = 60,
  parameter int unsigned MIN_MOD = 60
) (
  input  logic        clk_50mHz,
  input  logic        rst_n,
  input  logic        run,
  input  logic        clr,
  input  logic        down,
  output logic [15:0] q,
  output logic        wrap,
  output logic [6:0]  a_to_g,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
  localparam int unsigned SDIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned DW   = (DIV  > 1) ? $clog2(DIV)  : 1;
  localparam int unsigned SW   = (SDIV > 1) ? $clog2(SDIV) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [SW-1:0] SDIV_LAST = SW'(SDIV - 1);

  // Field maxima held as two-digit BCD so the wrap compare works on the BCD value directly.
  localparam logic [7:0] SEC_MAX = {4'((SEC_MOD - 1) / 10), 4'((SEC_MOD - 1) % 10)};
  localparam logic [7:0] MIN_MAX = {4'((MIN_MOD - 1) / 10), 4'((MIN_MOD - 1) % 10)};

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [7:0]    sec_q, min_q;
  logic [7:0]    sec_n, min_n;
  logic          wrap_c;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    dig_idx;
  logic [3:0]    digit;
  logic [6:0]    seg_n;
  logic [3:0]    an_n;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  assign tick = run && (div_cnt == DIV_LAST);
  assign q    = {min_q, sec_q};

  // Tick divider: advances only while running so a pause keeps the phase; clr restarts it.
  always_ff @(posedge clk_50mHz or negedge rst_n) begin
    if (!rst_n)      div_cnt <= '0;
    else if (clr)    div_cnt <= '0;
    else if (run)    div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  // Next count value for the two BCD fields, with wrap detection on the full mm:ss value.
  always_comb begin
    sec_n  = sec_q;
    min_n  = min_q;
    wrap_c = 1'b0;
    if (!down) begin
      if (sec_q == SEC_MAX) begin
        sec_n = 8'h00;
        if (min_q == MIN_MAX) begin
          min_n  = 8'h00;
          wrap_c = 1'b1;
        end else begin
          min_n = bcd_inc(min_q);
        end
      end else begin
        sec_n = bcd_inc(sec_q);
      end
    end else begin
      if (sec_q == 8'h00) begin
        sec_n = SEC_MAX;
        if (min_q == 8'h00) begin
          min_n  = MIN_MAX;
          wrap_c = 1'b1;
        end else begin
          min_n = bcd_dec(min_q);
        end
      end else begin
        sec_n = bcd_dec(sec_q);
      end
    end
  end

  // Count register and wrap pulse; clr wins over a coincident tick.
  always_ff @(posedge clk_50mHz or negedge rst_n) begin
    if (!rst_n) begin
      sec_q <= 8'h00;
      min_q <= 8'h00;
      wrap  <= 1'b0;
    end else if (clr) begin
      sec_q <= 8'h00;
      min_q <= 8'h00;
      wrap  <= 1'b0;
    end else begin
      wrap <= tick && wrap_c;
      if (tick) begin
        sec_q <= sec_n;
        min_q <= min_n;
      end
    end
  end

  // Scan divider and digit index; independent of run and clr.
  always_ff @(posedge clk_50mHz or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig_idx  <= 2'd0;
    end else if (scan_cnt == SDIV_LAST) begin
      scan_cnt <= '0;
      dig_idx  <= dig_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Select the digit under the scan index and build its segment/anode pattern.
  always_comb begin
    digit = 4'd0;
    an_n  = 4'b1110;
    case (dig_idx)
      2'd0: begin digit = sec_q[3:0]; an_n = 4'b1110; end
      2'd1: begin digit = sec_q[7:4]; an_n = 4'b1101; end
      2'd2: begin digit = min_q[3:0]; an_n = 4'b1011; end
      default: begin digit = min_q[7:4]; an_n = 4'b0111; end
    endcase
    seg_n = seg_decode(digit);
`ifdef LEAD_ZERO_BLANK_EN
    if (dig_idx == 2'd3 && min_q[7:4] == 4'd0) seg_n = 7'b1111111;
`endif
  end

  // Register segments, anodes and colon together so they switch on the same edge.
  always_ff @(posedge clk_50mHz or negedge rst_n) begin
    if (!rst_n) begin
      a_to_g <= 7'b0000001;
      an     <= 4'b1110;
      dp     <= 1'b1;
    end else begin
      a_to_g <= seg_n;
      an     <= an_n;
      dp     <= (dig_idx == 2'd2) ? 1'b0 : 1'b1;
    end
  end

endmodule

// File: doc/bcd_mmss_timer.md
# bcd_mmss_timer

Parametrised successor to the 0–59 seconds counter/display chain: a two-field BCD timer (minutes:seconds) driving a 4-digit multiplexed 7-segment display from a single 50 MHz clock. It adds run/pause, synchronous clear, up/down counting, programmable field moduli and a rollover pulse. It sits directly under the board top, replacing the separate 1 Hz generator, counter and display-driver instances.

## Interface
- CLK_HZ, 50_000_000: input clock frequency.
- TICK_HZ, 1: count rate; DIV = CLK_HZ/TICK_HZ, must be an integer ≥ 2.
- SCAN_HZ, 1000: digit-advance rate; SDIV = CLK_HZ/SCAN_HZ, must be an integer ≥ 2.
- SEC_MOD, 60: low-field modulus, 2..100.
- MIN_MOD, 60: high-field modulus, 2..100.

- clk_50mHz  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = count, 0 = pause (tick divider holds).
- clr  in  1  synchronous clear, level, one-cycle pulse sufficient.
- down  in  1  0 = count up, 1 = count down; sampled at each tick.
- q  out  16  BCD value {min_tens, min_units, sec_tens, sec_units}.
- wrap  out  1  one-cycle pulse when the full count wraps.
- a_to_g  out  7  segments {a..g}, active-low.
- an  out  4  digit enables, active-low, one-hot-low.
- dp  out  1  decimal point, active-low.

## Operation
- Reset (rst_n=0): tick divider=0, q=16'h0000, wrap=0, scan divider=0, digit index=0, an=4'b1110, a_to_g=7'b0000001 (digit "0"), dp=1.
- Tick divider: counts 0..DIV-1 only while run=1; holds value while run=0. Tick is asserted on the cycle the divider equals DIV-1 with run=1; divider then returns to 0.
- On tick, up mode: sec increments BCD; sec=SEC_MOD-1 → 0 and min increments; min=MIN_MOD-1 and sec=SEC_MOD-1 → both 0, wrap=1 for one cycle.
- On tick, down mode: sec decrements; sec=0 → SEC_MOD-1 and min decrements; both 0 → min=MIN_MOD-1, sec=SEC_MOD-1, wrap=1.
- BCD arithmetic per field: units 0..9, tens carry on units 9→0 / borrow on 0→9; field moduli compared on the full two-digit BCD value; values ≥ modulus never occur.
- clr=1: q=0, tick divider=0, wrap=0 on the next edge; clr has priority over a simultaneous tick. Scan logic is unaffected by clr and run.
- Scan: free-running divider 0..SDIV-1; on terminal count, digit index advances 0→1→2→3→0. Digit 0 = sec units (an=1110), 1 = sec tens (1101), 2 = min units (1011), 3 = min tens (0111).
- dp=0 only while digit 2 is selected (colon between mm and ss), else 1.
- Decoder: hex 0..9 to active-low segments (0 → 0000001, 1 → 1001111, ..., 9 → 0000100); a_to_g and an are registered together, so they always change on the same edge.

## Timing
- q updates on the clock edge where tick is asserted; first tick DIV cycles after run rises from a cleared state.
- wrap is registered, high exactly the cycle after the wrapping edge (same cycle q shows the wrapped value).
- Pause/resume: run=0 freezes divider phase; resume continues from the held phase with no lost or extra tick.
- Changing down between ticks takes effect on the next tick; no glitch in q.
- Each digit held for SDIV cycles; full refresh = 4·SDIV cycles.
- rst_n deasserted mid-count: all state returns to reset values immediately (asynchronous), independent of clock.

## Configuration
- LEAD_ZERO_BLANK_EN defined: when digit 3 is selected and min_tens=0, a_to_g=7'b1111111 (blank); an still selects digit 3. q unaffected.
- Undefined: all four digits always displayed, including leading zero.

## Test plan
(Bench parameters: CLK_HZ=20, TICK_HZ=1 → DIV=20; SCAN_HZ=5 → SDIV=4; SEC_MOD=60, MIN_MOD=60.)
- Reset then run=1 for 60 ticks (1200 cycles) → q steps 0000..0059, then 0100; no wrap pulse.
- Preload by counting to 5959, one more tick → q=0000, wrap=1 for exactly one cycle.
- From 0000, down=1, one tick → q=5959, wrap=1; next tick → 5958.
- run toggled low for 7 cycles mid-divider, then high → next q change delayed by exactly 7 cycles; clr asserted on a tick cycle → q=0000, no increment.
- With q=0123, observe 16 cycles → an sequence 1110,1101,1011,0111 each 4 cycles, a_to_g = 3,2,1,0 patterns, dp=0 only during 1011; with LEAD_ZERO_BLANK_EN, digit 3 shows 1111111.
- rst_n pulsed low asynchronously mid-count (between edges) → q=0000, an=1110, wrap=0 before the next clock edge.
